// File: rtl/int_mult_arbiter_if.sv
// Handshake and multiplier-side bus of int_mult_arbiter.
// slave is the arbiter's view; master is the requester/multiplier/consumer side.
interface int_mult_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_W       = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic                          mul_en;
    logic [DATA_WIDTH-1:0]         mul_plier;
    logic [DATA_WIDTH-1:0]         mul_cand;
    logic [2*DATA_WIDTH-1:0]       mul_result;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [2*DATA_WIDTH-1:0]       rsp_data;
    logic                          busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_result, rsp_ready,
        output req_ready, mul_en, mul_plier, mul_cand, rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_result, rsp_ready,
        input  req_ready, mul_en, mul_plier, mul_cand, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/int_mult_arbiter.sv
// Round-robin sharing of one free-running pipelined multiplier between NUM_REQ requesters,
// with a tag pipe tracking issues and a credit-protected first-word fall-through response FIFO.
module int_mult_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int MULT_LATENCY = 5,
    parameter int RESP_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              rst,
    int_mult_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int PW   = $clog2(RESP_DEPTH);
    localparam int CW   = PW + 1;
    localparam int IW   = $clog2(MULT_LATENCY + 1);
    localparam int SW   = $clog2(RESP_DEPTH + MULT_LATENCY + 1) + 1;

    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W:0]           scan_idx;
    logic                    can_issue;
    logic                    gnt;
    logic [ID_W-1:0]         gnt_id;

    logic                    tag_vld [MULT_LATENCY];
    logic [ID_W-1:0]         tag_id  [MULT_LATENCY];
    logic [IW-1:0]           inflight;

    logic [ID_W-1:0]         mem_id   [RESP_DEPTH];
    logic [2*DATA_WIDTH-1:0] mem_data [RESP_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic                    full;
    logic                    push;
    logic                    pop;
    logic                    rsp_valid;

    // Credit counts FIFO occupancy plus everything still inside the multiplier.
    assign can_issue = !rst && ((SW'(inflight) + SW'(count)) < SW'(RESP_DEPTH));

    always_comb begin
        gnt      = 1'b0;
        gnt_id   = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (scan_idx >= (ID_W+1)'(NUM_REQ))
                scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
            if (can_issue && !gnt && bus.req_valid[scan_idx[ID_W-1:0]]) begin
                gnt    = 1'b1;
                gnt_id = scan_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (gnt)
            bus.req_ready[gnt_id] = 1'b1;
    end

    assign bus.mul_en    = !rst;
    assign bus.mul_plier = gnt ? bus.req_a[DATA_WIDTH*gnt_id +: DATA_WIDTH] : '0;
    assign bus.mul_cand  = gnt ? bus.req_b[DATA_WIDTH*gnt_id +: DATA_WIDTH] : '0;

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (gnt)
            rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MULT_LATENCY; i++) begin
                tag_vld[i] <= 1'b0;
                tag_id[i]  <= '0;
            end
        end else begin
            tag_vld[0] <= gnt;
            tag_id[0]  <= gnt_id;
            for (int i = 1; i < MULT_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    // Exiting tag and the multiplier output line up in the same cycle.
    assign push      = !rst && tag_vld[MULT_LATENCY-1];
    assign rsp_valid = !rst && (count != '0);
    assign pop       = rsp_valid && bus.rsp_ready;
    assign full      = (count == CW'(RESP_DEPTH));

    always_ff @(posedge clk) begin
        if (rst)
            inflight <= '0;
        else if (gnt && !push)
            inflight <= inflight + 1'b1;
        else if (!gnt && push)
            inflight <= inflight - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr]   <= tag_id[MULT_LATENCY-1];
            mem_data[wr_ptr] <= bus.mul_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_valid ? mem_id[rd_ptr]   : '0;
    assign bus.rsp_data  = rsp_valid ? mem_data[rd_ptr] : '0;
    assign bus.busy      = !rst && ((inflight != '0) || (count != '0));
endmodule

// File: tb/tb_int_mult_arbiter.sv
// Self-checking bench for int_mult_arbiter: queue-based reference model checked every cycle,
// a table of single-op vectors, hand-written corner sequences and a randomized phase.
module tb_int_mult_arbiter;
    localparam int NR    = 4;
    localparam int DW    = 32;
    localparam int LAT   = 5;
    localparam int DEPTH = 8;
    localparam int IDW   = $clog2(NR);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int_mult_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    int_mult_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .MULT_LATENCY(LAT), .RESP_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running external multiplier
    logic [2*DW-1:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= {{DW{1'b0}}, bus.mul_plier} * {{DW{1'b0}}, bus.mul_cand};
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.mul_result = mpipe[LAT-1];

    typedef struct { int id; logic [2*DW-1:0] prod; int exit_cyc; } fl_t;
    typedef struct { int id; logic [2*DW-1:0] prod; } rsp_t;
    typedef struct { int id; logic [DW-1:0] a; logic [DW-1:0] b; logic [2*DW-1:0] prod; } vec_t;

    fl_t  m_pipe [$];
    rsp_t m_fifo [$];
    int   m_rr;
    int   cyc;
    int   n_tests;
    int   n_fail;
    logic [NR-1:0] last_ready;

    task automatic chk(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    // One clock: compare outputs with the model mid-cycle, then advance the model at the edge.
    task automatic step();
        int gid;
        int k;
        logic [NR-1:0]   exp_ready;
        logic [DW-1:0]   exp_pl, exp_ca;
        logic            exp_rv, pop;
        logic [IDW-1:0]  exp_id;
        logic [2*DW-1:0] exp_data;
        @(negedge clk);
        gid = -1;
        exp_ready = '0;
        exp_pl = '0;
        exp_ca = '0;
        if (!rst && (m_pipe.size() + m_fifo.size() < DEPTH)) begin
            for (int i = 0; i < NR; i++) begin
                k = (m_rr + i) % NR;
                if (gid < 0 && bus.req_valid[k]) gid = k;
            end
        end
        if (gid >= 0) begin
            exp_ready[gid] = 1'b1;
            exp_pl = bus.req_a[gid*DW +: DW];
            exp_ca = bus.req_b[gid*DW +: DW];
        end
        exp_rv   = !rst && (m_fifo.size() > 0);
        exp_id   = exp_rv ? IDW'(m_fifo[0].id) : '0;
        exp_data = exp_rv ? m_fifo[0].prod : '0;
        last_ready = bus.req_ready;
        chk("req_ready", 2*DW'(bus.req_ready), 2*DW'(exp_ready));
        chk("mul_plier", 2*DW'(bus.mul_plier), 2*DW'(exp_pl));
        chk("mul_cand",  2*DW'(bus.mul_cand),  2*DW'(exp_ca));
        chk("mul_en",    2*DW'(bus.mul_en),    2*DW'(!rst));
        chk("rsp_valid", 2*DW'(bus.rsp_valid), 2*DW'(exp_rv));
        chk("rsp_id",    2*DW'(bus.rsp_id),    2*DW'(exp_id));
        chk("rsp_data",  bus.rsp_data,         exp_data);
        chk("busy", 2*DW'(bus.busy), 2*DW'(!rst && (m_pipe.size() + m_fifo.size() > 0)));
        pop = exp_rv && bus.rsp_ready;
        @(posedge clk);
        if (rst) begin
            m_pipe.delete();
            m_fifo.delete();
            m_rr = 0;
        end else begin
            if (pop) void'(m_fifo.pop_front());
            while (m_pipe.size() > 0 && m_pipe[0].exit_cyc == cyc) begin
                m_fifo.push_back('{m_pipe[0].id, m_pipe[0].prod});
                void'(m_pipe.pop_front());
            end
            if (gid >= 0) begin
                m_pipe.push_back('{gid, {{DW{1'b0}}, exp_pl} * {{DW{1'b0}}, exp_ca}, cyc + LAT});
                m_rr = (gid + 1) % NR;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic set_op(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_a[k*DW +: DW] = a;
        bus.req_b[k*DW +: DW] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.req_valid = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    vec_t vecs [6];
    int   n_wait;
    int   grants;

    initial begin
        vecs[0] = '{0, 32'd7,          32'd6,          64'd42};
        vecs[1] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{3, 32'd0,          32'h1234_5678, 64'd0};
        vecs[3] = '{1, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
        vecs[4] = '{3, 32'h8000_0000, 32'd2,          64'h0000_0001_0000_0000};
        vecs[5] = '{1, 32'd1,          32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF};

        n_tests = 0; n_fail = 0; cyc = 0; m_rr = 0;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        #1;
        step();
        step();
        rst = 1'b0;
        idle(2);

        // Single-op vectors: exact latency, id and product
        foreach (vecs[v]) begin
            set_op(vecs[v].id, vecs[v].a, vecs[v].b);
            bus.req_valid = NR'(1) << vecs[v].id;
            step();
            chk("vec_grant", 2*DW'(last_ready), 2*DW'(NR'(1) << vecs[v].id));
            bus.req_valid = '0;
            n_wait = 1;
            while (!bus.rsp_valid && n_wait < 20) begin
                step();
                n_wait++;
            end
            chk("vec_latency", 2*DW'(n_wait), 2*DW'(LAT + 1));
            chk("vec_id",      2*DW'(bus.rsp_id), 2*DW'(vecs[v].id));
            chk("vec_data",    bus.rsp_data, vecs[v].prod);
            idle(2);
        end

        // All requesters valid: strict rotation
        do_reset();
        set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int k = 1; k < NR; k++) set_op(k, $urandom, $urandom);
        bus.req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_order", 2*DW'(last_ready), 2*DW'(NR'(1) << (i % NR)));
        end
        idle(12);

        // Backpressure: credit stops issue at FIFO depth
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        grants = 0;
        for (int i = 0; i < 20; i++) begin
            set_op(1, $urandom, $urandom);
            step();
            if (last_ready != '0) grants++;
        end
        chk("fill_issues", 2*DW'(grants), 2*DW'(DEPTH));
        bus.rsp_ready = 1'b1;
        step();
        chk("resume_wait", 2*DW'(last_ready), 2*DW'(0));
        step();
        chk("resume", 2*DW'(last_ready), 2*DW'(4'b0010));
        // Near-full steady state with interleaved pushes and pops
        for (int i = 0; i < 30; i++) begin
            set_op(1, $urandom, $urandom);
            bus.rsp_ready = (i % 3) != 0;
            step();
        end
        bus.rsp_ready = 1'b1;
        idle(20);

        // Reset with ops in flight and in the FIFO
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            set_op(0, $urandom, $urandom);
            set_op(2, $urandom, $urandom);
            step();
        end
        bus.req_valid = '0;
        step();
        step();
        chk("pre_rst_valid", 2*DW'(bus.rsp_valid), 2*DW'(1));
        do_reset();
        chk("post_rst_valid", 2*DW'(bus.rsp_valid), 2*DW'(0));
        chk("post_rst_busy",  2*DW'(bus.busy),      2*DW'(0));
        bus.rsp_ready = 1'b1;
        idle(12);
        bus.req_valid = 4'b0011;
        step();
        chk("post_rst_rr", 2*DW'(last_ready), 2*DW'(4'b0001));
        idle(10);

        // Pointer at 2, only req0 and req3 valid
        bus.req_valid = 4'b0010;
        step();
        bus.req_valid = 4'b1001;
        step();
        chk("wrap_first",  2*DW'(last_ready), 2*DW'(4'b1000));
        step();
        chk("wrap_second", 2*DW'(last_ready), 2*DW'(4'b0001));
        idle(10);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            bus.req_valid = NR'($urandom);
            for (int k = 0; k < NR; k++) set_op(k, $urandom, $urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 249) == 0);
            step();
        end
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
